partition_output_packetizer: RTL and testbench
==============================================

Name: partition_output_packetizer

Overview:
Downstream stage of the partition compute kernel. It consumes the kernel's unpacked result vector over a valid/ready handshake and serializes each result into 8-bit AXI-Stream beats. It asserts tlast to close a frame after a fixed number of results. Its output feeds the clock-domain-crossing FIFO toward the network side, and it replaces the standalone pack-and-subset-convert path.

Parameters:
- OUT_WIDTH, 4, bit width of one result element
- OUT_SIZE, 2, number of elements per result vector
- RESULTS_PER_FRAME, 4, results per AXI-Stream frame (tlast period); must be >= 1
- Derived, not overridable: TOTAL_BITS = OUT_WIDTH*OUT_SIZE
- Derived, not overridable: BEATS = ceil(TOTAL_BITS/8)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- data_in  input  [OUT_WIDTH-1:0] x [OUT_SIZE-1:0] (unpacked)  result vector from kernel
- data_in_valid  input  1  result valid
- data_in_ready  output  1  block can accept a result
- m_axis_tdata  output  8  output byte
- m_axis_tvalid  output  1  output beat valid
- m_axis_tlast  output  1  last beat of frame
- m_axis_tready  input  1  downstream accepts beat
- frame_count  output  16  number of completed frames, wraps at 2^16

Behaviour:
- Reset (async assert, takes effect immediately): state=IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, beat_cnt=0, result_cnt=0, frame_count=0. data_in_ready=0 while rst is high, 1 after release.
- Packing: V = {data_in[OUT_SIZE-1], ..., data_in[0]}, zero-extended at the MSB end to BEATS*8 bits. Beats go out most-significant byte first. Beat k carries V[BEATS*8-1-8k -: 8].
- State IDLE: data_in_ready=1, m_axis_tvalid=0.
  - On data_in_valid&&data_in_ready, register V into the shift register and go to SEND with beat_cnt=0.
  - Latency: first beat is valid the cycle after acceptance.
- State SEND: m_axis_tvalid=1 and tdata = current beat.
  - tdata and tlast stay stable while tvalid&&!tready (AXI rule); no beat is dropped or repeated.
  - On a handshake with beat_cnt<BEATS-1: advance to the next beat, beat_cnt++.
  - On a handshake with beat_cnt==BEATS-1: the result is complete and result_cnt increments, wrapping at RESULTS_PER_FRAME.
- Back-to-back results: in SEND, data_in_ready = (beat_cnt==BEATS-1) && m_axis_tready. This is a combinational path from tready, and it is permitted.
  - If data_in_valid is also high, load the new V and stay in SEND with beat_cnt=0, with no bubble.
  - Otherwise return to IDLE.
  - With BEATS=1 this sustains one result per cycle.
- tlast: m_axis_tlast=1 only on the last beat (beat_cnt==BEATS-1) of the result whose result_cnt==RESULTS_PER_FRAME-1. Otherwise 0.
- frame_count increments by 1 on the handshake of each tlast beat. It wraps from 16'hFFFF to 0.
- RESULTS_PER_FRAME=1: every result's last beat carries tlast.
- data_in is sampled only on the accept handshake. Changes while not accepted are ignored.
- Reset mid-frame: the partial frame is discarded with no tlast emitted. The next accepted result starts a new frame at result_cnt=0.
- Gaps in data_in_valid between results of a frame do not close the frame. tlast depends only on the result count.

Test Plan:
- Defaults; after reset, check outputs → m_axis_tvalid=0, tlast=0, frame_count=0, data_in_ready=1.
- Defaults; data_in[1]=4'hA, data_in[0]=4'h3, tready=1 → tdata=8'hA3 one cycle after accept, tvalid for 1 cycle, tlast=0.
- Defaults; 8 results 8'h01..8'h08 streamed continuously, tready=1 → 8 consecutive beats, tlast on 8'h04 and 8'h08, frame_count=2, data_in_ready never low.
- OUT_WIDTH=10, OUT_SIZE=2; data_in[1]=10'h3FF, data_in[0]=10'h001 → beats 8'h0F, 8'hFC, 8'h01; data_in_ready low during the first two beats.
- Defaults; tready held 0 for 5 cycles with data 8'h5C pending → tdata=8'h5C and tvalid=1 stable throughout, data_in_ready=0; a second result waits and emerges only after tready rises.
- Defaults; rst pulsed after 2 results of a frame, then 4 results sent → tlast only on the 4th post-reset result, frame_count=1.

Source files
------------

// File: rtl/partition_output_packetizer.sv
// Serializes each kernel result vector into MSB-first 8-bit AXI-Stream beats and
// closes a frame with tlast after every RESULTS_PER_FRAME results.
module partition_output_packetizer #(
  parameter int OUT_WIDTH         = 4,
  parameter int OUT_SIZE          = 2,
  parameter int RESULTS_PER_FRAME = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OUT_WIDTH-1:0] data_in [OUT_SIZE-1:0],
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [15:0]          frame_count
);

  localparam int TOTAL_BITS = OUT_WIDTH * OUT_SIZE;
  localparam int BEATS      = (TOTAL_BITS + 7) / 8;
  localparam int PW         = BEATS * 8;
  localparam int BCW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RCW        = (RESULTS_PER_FRAME > 1) ? $clog2(RESULTS_PER_FRAME) : 1;
  localparam logic [BCW-1:0] LAST_BEAT   = BCW'(BEATS - 1);
  localparam logic [RCW-1:0] LAST_RESULT = RCW'(RESULTS_PER_FRAME - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state;
  logic [PW-1:0]  shreg;
  logic [PW-1:0]  packed_v;
  logic [BCW-1:0] beat_cnt;
  logic [RCW-1:0] result_cnt;
  logic [RCW-1:0] result_next;
  logic           last_beat;
  logic           done;
  logic           accept;

  always_comb begin
    packed_v = '0;
    for (int i = 0; i < OUT_SIZE; i++) begin
      packed_v[i*OUT_WIDTH +: OUT_WIDTH] = data_in[i];
    end
  end

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign done      = m_axis_tvalid && m_axis_tready && last_beat;

  // A new result may be taken in the same cycle the final beat of the previous
  // one is handshaken, which keeps the stream free of bubbles.
  assign data_in_ready = !rst && ((state == IDLE) || (last_beat && m_axis_tready));
  assign accept        = data_in_valid && data_in_ready;

  assign result_next  = done ? ((result_cnt == LAST_RESULT) ? '0 : result_cnt + 1'b1)
                             : result_cnt;
  assign m_axis_tdata = shreg[PW-1 -: 8];

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; the shift register is reset too because tdata must read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      shreg         <= '0;
      beat_cnt      <= '0;
      result_cnt    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_count   <= '0;
    end else begin
      result_cnt <= result_next;
      if (done && m_axis_tlast) begin
        frame_count <= frame_count + 1'b1;
      end

      if (accept) begin
        state         <= SEND;
        shreg         <= packed_v;
        beat_cnt      <= '0;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (BEATS == 1) && (result_next == LAST_RESULT);
      end else if (m_axis_tvalid && m_axis_tready) begin
        if (last_beat) begin
          state         <= IDLE;
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
        end else begin
          shreg         <= shreg << 8;
          beat_cnt      <= beat_cnt + 1'b1;
          m_axis_tlast  <= ((beat_cnt + 1'b1) == LAST_BEAT) && (result_cnt == LAST_RESULT);
        end
      end
    end
  end

endmodule

// File: tb/tb_partition_output_packetizer.sv
// Checks the packetizer against a queue-of-beats reference model with random and
// directed traffic, plus a wide-element instance exercising multi-beat results.
module tb_partition_output_packetizer;

  localparam int RPF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance: 2 x 4-bit elements, one beat per result.
  logic [3:0]  d0 [1:0];
  logic        v0 = 1'b0;
  logic        ready0;
  logic [7:0]  tdata0;
  logic        tvalid0, tlast0;
  logic        tready0 = 1'b0;
  logic [15:0] fc0;

  partition_output_packetizer #(.OUT_WIDTH(4), .OUT_SIZE(2), .RESULTS_PER_FRAME(RPF)) dut0 (
    .clk(clk), .rst(rst), .data_in(d0), .data_in_valid(v0), .data_in_ready(ready0),
    .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tlast(tlast0),
    .m_axis_tready(tready0), .frame_count(fc0)
  );

  // Wide instance: 2 x 10-bit elements, three beats per result, tlast every result.
  logic [9:0]  d1 [1:0];
  logic        v1 = 1'b0;
  logic        ready1;
  logic [7:0]  tdata1;
  logic        tvalid1, tlast1;
  logic        tready1 = 1'b0;
  logic [15:0] fc1;

  partition_output_packetizer #(.OUT_WIDTH(10), .OUT_SIZE(2), .RESULTS_PER_FRAME(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(d1), .data_in_valid(v1), .data_in_ready(ready1),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tlast(tlast1),
    .m_axis_tready(tready1), .frame_count(fc1)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t q[$];
  int    m_rc = 0;
  int    m_fc = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("tvalid", 32'(tvalid0), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("tdata", 32'(tdata0), 32'(q[0].data));
      check("tlast", 32'(tlast0), 32'(q[0].last));
    end else begin
      check("tlast_idle", 32'(tlast0), 32'd0);
    end
    check("frame_count", 32'(fc0), 32'(16'(m_fc)));
  endtask

  // One clock of dut0: drive, check ready, advance the model, compare after the edge.
  task automatic step(input logic r, input logic v, input logic [3:0] hi,
                      input logic [3:0] lo, input logic tr);
    logic exp_ready, hs, acc;
    rst = r; v0 = v; d0[1] = hi; d0[0] = lo; tready0 = tr;
    #1;
    exp_ready = !r && (q.size() == 0 || (q.size() == 1 && tr));
    check("data_in_ready", 32'(ready0), 32'(exp_ready));
    if (r) begin
      q.delete();
      m_rc = 0;
      m_fc = 0;
    end else begin
      hs  = (q.size() > 0) && tr;
      acc = v && exp_ready;
      if (hs) begin
        if (q[0].last) m_fc++;
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back('{data: {hi, lo}, last: (m_rc == RPF - 1)});
        m_rc = (m_rc + 1) % RPF;
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  logic [7:0] exp_b [6];

  initial begin
    d0[0] = '0; d0[1] = '0; d1[0] = '0; d1[1] = '0;

    // Reset state
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    check("rst_tvalid", 32'(tvalid0), 32'd0);
    check("rst_tlast", 32'(tlast0), 32'd0);
    check("rst_fc", 32'(fc0), 32'd0);
    check("rst_ready", 32'(ready0), 32'd1);
    check("rst_ready_wide", 32'(ready1), 32'd1);

    // Wide instance: {3FF,001} -> 0F FC 01, then back-to-back {155,2AA} -> 05 56 AA
    exp_b = '{8'h0F, 8'hFC, 8'h01, 8'h05, 8'h56, 8'hAA};
    v1 = 1'b1; d1[1] = 10'h3FF; d1[0] = 10'h001; tready1 = 1'b1;
    #1 check("wide_ready_idle", 32'(ready1), 32'd1);
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      v1 = (k == 2);
      if (k == 2) begin
        d1[1] = 10'h155; d1[0] = 10'h2AA;
      end else begin
        d1[1] = 10'h000; d1[0] = 10'h000;
      end
      check("wide_tvalid", 32'(tvalid1), 32'd1);
      check("wide_tdata", 32'(tdata1), 32'(exp_b[k]));
      check("wide_tlast", 32'(tlast1), 32'(k == 2 || k == 5));
      #1 check("wide_ready", 32'(ready1), 32'(k % 3 == 2));
      @(posedge clk); @(negedge clk);
    end
    check("wide_done_tvalid", 32'(tvalid1), 32'd0);
    check("wide_fc", 32'(fc1), 32'd2);
    tready1 = 1'b0;

    // Single result A3
    step(1'b0, 1'b1, 4'hA, 4'h3, 1'b1);
    check("a3_tdata", 32'(tdata0), 32'h A3);
    check("a3_tvalid", 32'(tvalid0), 32'd1);
    check("a3_tlast", 32'(tlast0), 32'd0);
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    check("a3_one_beat", 32'(tvalid0), 32'd0);

    // Continuous stream 01..08 from a fresh frame
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 4'h0, 4'(i), 1'b1);
      check("stream_tdata", 32'(tdata0), 32'(i));
      check("stream_tlast", 32'(tlast0), 32'(i % 4 == 0));
      check("stream_ready", 32'(ready0), 32'd1);
    end
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    check("stream_fc", 32'(fc0), 32'd2);

    // Backpressure: 5C held, second result 77 waits
    step(1'b0, 1'b1, 4'h5, 4'hC, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 4'h7, 4'h7, 1'b0);
      check("stall_tdata", 32'(tdata0), 32'h5C);
      check("stall_tvalid", 32'(tvalid0), 32'd1);
      check("stall_ready", 32'(ready0), 32'd0);
    end
    step(1'b0, 1'b1, 4'h7, 4'h7, 1'b1);
    check("stall_next", 32'(tdata0), 32'h77);
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);

    // Reset mid-frame discards the partial frame
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 4'h1, 4'h1, 1'b1);
    step(1'b0, 1'b1, 4'h2, 4'h2, 1'b1);
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    check("midrst_fc", 32'(fc0), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, 4'h9, 4'(i), 1'b1);
      check("midrst_tlast", 32'(tlast0), 32'(i == 4));
    end
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    check("midrst_fc_after", 32'(fc0), 32'd1);

    // Random traffic with gaps, backpressure and occasional reset
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 249) == 0, $urandom_range(0, 3) != 0,
           4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
